// File: rtl/maj_vote_tmr.sv
// maj_vote_tmr: registered N-channel bitwise majority voter with
// per-channel consecutive-mismatch supervision and sticky fault flags.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous reset, active-low
//   in_valid   ch_data holds a sample this cycle
//   ch_data    N_CH words, channel k at [k*WIDTH +: WIDTH]
//   clr_fault  synchronous clear of all counters and fault flags
//   out_valid  out_data holds a voted word
//   out_data   registered bitwise majority
//   mismatch   bit k = channel k differed from the vote on the last valid sample
//   fault      sticky per-channel fault flags
//   any_fault  OR of fault (registered alongside it)
//   err_cnt    per-channel consecutive-mismatch counters, channel k at [k*CNT_W +: CNT_W]
module maj_vote_tmr #(
    parameter int unsigned N_CH      = 3,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ERR_LIMIT = 4,
    parameter int unsigned CNT_W     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [N_CH*WIDTH-1:0]   ch_data,
    input  logic                    clr_fault,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [N_CH-1:0]         mismatch,
    output logic [N_CH-1:0]         fault,
    output logic                    any_fault,
    output logic [N_CH*CNT_W-1:0]   err_cnt
);

    localparam int unsigned PC_W = $clog2(N_CH + 1);
    localparam int unsigned HALF = N_CH / 2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(ERR_LIMIT);

    // Parameter legality checks at elaboration
    if ((N_CH < 3) || ((N_CH % 2) == 0)) begin : g_bad_nch
        $error("maj_vote_tmr: N_CH must be odd and >= 3");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("maj_vote_tmr: WIDTH must be >= 1");
    end
    if ((ERR_LIMIT < 1) || (ERR_LIMIT > ((2 ** CNT_W) - 1))) begin : g_bad_limit
        $error("maj_vote_tmr: ERR_LIMIT must be in 1 .. 2^CNT_W-1");
    end

    logic                        out_valid_q, out_valid_d;
    logic [WIDTH-1:0]            out_data_q,  out_data_d;
    logic [N_CH-1:0]             mm_q,        mm_d;
    logic [N_CH-1:0]             fault_q,     fault_d;
    logic                        any_fault_q;
    logic [N_CH-1:0][CNT_W-1:0]  cnt_q,       cnt_d;

    logic [WIDTH-1:0]            vote_c;
    logic [N_CH-1:0]             mm_c;

    // Bitwise majority: popcount per bit position against N_CH/2
    always_comb begin : p_vote
        logic [PC_W-1:0] ones;
        ones   = '0;
        vote_c = '0;
        for (int b = 0; b < int'(WIDTH); b++) begin
            ones = '0;
            for (int k = 0; k < int'(N_CH); k++) begin
                ones = ones + PC_W'(ch_data[k*WIDTH + b]);
            end
            vote_c[b] = (ones > PC_W'(HALF));
        end
    end

    // Per-channel disagreement with the current vote
    always_comb begin : p_mm
        mm_c = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            mm_c[k] = (ch_data[k*WIDTH +: WIDTH] != vote_c);
        end
    end

    // Next-state: output capture and per-channel OK/SUSPECT/FAULT counters
    always_comb begin : p_next
        logic [CNT_W-1:0] inc;
        inc         = '0;
        out_valid_d = in_valid;
        out_data_d  = out_data_q;
        mm_d        = mm_q;
        fault_d     = fault_q;
        cnt_d       = cnt_q;
        if (in_valid) begin
            out_data_d = vote_c;
            mm_d       = mm_c;
            for (int k = 0; k < int'(N_CH); k++) begin
                if (mm_c[k]) begin
                    // saturate rather than wrap so a permanently bad channel stays visible
                    inc = (cnt_q[k] == CNT_MAX) ? cnt_q[k] : (cnt_q[k] + CNT_W'(1));
                    cnt_d[k] = inc;
                    if (inc == LIMIT) begin
                        fault_d[k] = 1'b1;
                    end
                end else if (!fault_q[k]) begin
                    cnt_d[k] = '0;
                end
            end
        end
        // clear overrides any increment or fault set on the same edge
        if (clr_fault) begin
            cnt_d   = '0;
            fault_d = '0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            mm_q        <= '0;
            fault_q     <= '0;
            any_fault_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            mm_q        <= mm_d;
            fault_q     <= fault_d;
            any_fault_q <= |fault_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign mismatch  = mm_q;
    assign fault     = fault_q;
    assign any_fault = any_fault_q;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_maj_vote_tmr.sv
// Directed bench for maj_vote_tmr: a vector table on the default
// TMR configuration, plus short sequences on a 5-channel 1-bit voter
// and a 3-channel voter with ERR_LIMIT=1 / 2-bit counters.
module tb_maj_vote_tmr;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // default: N_CH=3 WIDTH=8 ERR_LIMIT=4 CNT_W=4
    logic        v1, c1;
    logic [23:0] d1;
    logic        ov1, af1;
    logic [7:0]  od1;
    logic [2:0]  mm1, f1;
    logic [11:0] ec1;

    // N_CH=5 WIDTH=1
    logic        v5, c5;
    logic [4:0]  d5;
    logic        ov5, af5;
    logic [0:0]  od5;
    logic [4:0]  mm5, f5;
    logic [19:0] ec5;

    // N_CH=3 WIDTH=8 ERR_LIMIT=1 CNT_W=2
    logic        v3, c3;
    logic [23:0] d3;
    logic        ov3, af3;
    logic [7:0]  od3;
    logic [2:0]  mm3, f3;
    logic [5:0]  ec3;

    maj_vote_tmr u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .ch_data(d1), .clr_fault(c1),
        .out_valid(ov1), .out_data(od1), .mismatch(mm1), .fault(f1),
        .any_fault(af1), .err_cnt(ec1)
    );

    maj_vote_tmr #(.N_CH(5), .WIDTH(1), .ERR_LIMIT(4), .CNT_W(4)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(v5), .ch_data(d5), .clr_fault(c5),
        .out_valid(ov5), .out_data(od5), .mismatch(mm5), .fault(f5),
        .any_fault(af5), .err_cnt(ec5)
    );

    maj_vote_tmr #(.N_CH(3), .WIDTH(8), .ERR_LIMIT(1), .CNT_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v3), .ch_data(d3), .clr_fault(c3),
        .out_valid(ov3), .out_data(od3), .mismatch(mm3), .fault(f3),
        .any_fault(af3), .err_cnt(ec3)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        v;
        logic        c;
        logic [23:0] d;
        logic        ev;
        logic [7:0]  eo;
        logic [2:0]  emm;
        logic [2:0]  ef;
        logic        ea;
        logic [11:0] ec;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        v1 = 0; c1 = 0; d1 = '0;
        v5 = 0; c5 = 0; d5 = '0;
        v3 = 0; c3 = 0; d3 = '0;

        // ch_data = {ch2,ch1,ch0}; err_cnt = {c2,c1,c0}
        //            v     c     data         ev    out    mm      fault   any   cnt
        vecs.push_back('{1'b1, 1'b0, 24'h5AA5A5, 1'b1, 8'hA5, 3'b100, 3'b000, 1'b0, 12'h100});
        vecs.push_back('{1'b0, 1'b1, 24'h000000, 1'b0, 8'hA5, 3'b100, 3'b000, 1'b0, 12'h000});
        vecs.push_back('{1'b1, 1'b0, 24'hAACCF0, 1'b1, 8'hE8, 3'b111, 3'b000, 1'b0, 12'h111});
        vecs.push_back('{1'b1, 1'b0, 24'h111111, 1'b1, 8'h11, 3'b000, 3'b000, 1'b0, 12'h000});
        // ch1 fault onset with gaps
        vecs.push_back('{1'b1, 1'b0, 24'h00FF00, 1'b1, 8'h00, 3'b010, 3'b000, 1'b0, 12'h010});
        vecs.push_back('{1'b0, 1'b0, 24'h000000, 1'b0, 8'h00, 3'b010, 3'b000, 1'b0, 12'h010});
        vecs.push_back('{1'b1, 1'b0, 24'h00FF00, 1'b1, 8'h00, 3'b010, 3'b000, 1'b0, 12'h020});
        vecs.push_back('{1'b0, 1'b0, 24'h000000, 1'b0, 8'h00, 3'b010, 3'b000, 1'b0, 12'h020});
        vecs.push_back('{1'b1, 1'b0, 24'h00FF00, 1'b1, 8'h00, 3'b010, 3'b000, 1'b0, 12'h030});
        vecs.push_back('{1'b0, 1'b0, 24'h000000, 1'b0, 8'h00, 3'b010, 3'b000, 1'b0, 12'h030});
        vecs.push_back('{1'b1, 1'b0, 24'h00FF00, 1'b1, 8'h00, 3'b010, 3'b010, 1'b1, 12'h040});
        vecs.push_back('{1'b0, 1'b0, 24'h000000, 1'b0, 8'h00, 3'b010, 3'b010, 1'b1, 12'h040});
        vecs.push_back('{1'b1, 1'b0, 24'h222222, 1'b1, 8'h22, 3'b000, 3'b010, 1'b1, 12'h040});
        vecs.push_back('{1'b1, 1'b0, 24'h00FF00, 1'b1, 8'h00, 3'b010, 3'b010, 1'b1, 12'h050});
        vecs.push_back('{1'b0, 1'b1, 24'h000000, 1'b0, 8'h00, 3'b010, 3'b000, 1'b0, 12'h000});
        // ch2 counter reset on match
        vecs.push_back('{1'b1, 1'b0, 24'hFF0000, 1'b1, 8'h00, 3'b100, 3'b000, 1'b0, 12'h100});
        vecs.push_back('{1'b1, 1'b0, 24'hFF0000, 1'b1, 8'h00, 3'b100, 3'b000, 1'b0, 12'h200});
        vecs.push_back('{1'b1, 1'b0, 24'hFF0000, 1'b1, 8'h00, 3'b100, 3'b000, 1'b0, 12'h300});
        vecs.push_back('{1'b1, 1'b0, 24'h333333, 1'b1, 8'h33, 3'b000, 3'b000, 1'b0, 12'h000});
        // ch0 clear priority on the 4th mismatch
        vecs.push_back('{1'b1, 1'b0, 24'h0000FF, 1'b1, 8'h00, 3'b001, 3'b000, 1'b0, 12'h001});
        vecs.push_back('{1'b1, 1'b0, 24'h0000FF, 1'b1, 8'h00, 3'b001, 3'b000, 1'b0, 12'h002});
        vecs.push_back('{1'b1, 1'b0, 24'h0000FF, 1'b1, 8'h00, 3'b001, 3'b000, 1'b0, 12'h003});
        vecs.push_back('{1'b1, 1'b1, 24'h0000FF, 1'b1, 8'h00, 3'b001, 3'b000, 1'b0, 12'h000});

        // reset state
        #12;
        chk("reset out_valid", 32'(ov1), 32'h0);
        chk("reset out_data",  32'(od1), 32'h0);
        chk("reset err_cnt",   32'(ec1), 32'h0);
        chk("reset fault",     32'(f1),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            v1 = vecs[i].v;
            c1 = vecs[i].c;
            d1 = vecs[i].d;
            step();
            chk($sformatf("row%0d out_valid", i), 32'(ov1), 32'(vecs[i].ev));
            chk($sformatf("row%0d out_data", i),  32'(od1), 32'(vecs[i].eo));
            chk($sformatf("row%0d mismatch", i),  32'(mm1), 32'(vecs[i].emm));
            chk($sformatf("row%0d fault", i),     32'(f1),  32'(vecs[i].ef));
            chk($sformatf("row%0d any_fault", i), 32'(af1), 32'(vecs[i].ea));
            chk($sformatf("row%0d err_cnt", i),   32'(ec1), 32'(vecs[i].ec));
        end
        v1 = 0; c1 = 0; d1 = '0;

        // ERR_LIMIT=1: fault on first mismatch; 2-bit counter saturates at 3
        v3 = 1'b1;
        d3 = 24'h00FF00;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("lim1 s%0d fault", i),     32'(f3),  32'h2);
            chk($sformatf("lim1 s%0d any_fault", i), 32'(af3), 32'h1);
            chk($sformatf("lim1 s%0d err_cnt", i),   32'(ec3), 32'((i > 3 ? 3 : i) << 2));
        end

        // 5-channel 1-bit vote with all three DUTs valid, then reset mid-cycle
        v1 = 1'b1; d1 = 24'h5AA5A5;
        v5 = 1'b1; d5 = 5'b10011;   // ch0..ch4 = 1,1,0,0,1
        step();
        chk("n5 out_valid", 32'(ov5), 32'h1);
        chk("n5 out_data",  32'(od5), 32'h1);
        chk("n5 mismatch",  32'(mm5), 32'h0C);
        chk("n5 err_cnt",   32'(ec5), 32'h01100);
        chk("pre-rst out_valid", 32'(ov1), 32'h1);
        chk("pre-rst out_data",  32'(od1), 32'hA5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-rst out_valid",  32'(ov1), 32'h0);
        chk("mid-rst out_data",   32'(od1), 32'h0);
        chk("mid-rst err_cnt",    32'(ec1), 32'h0);
        chk("mid-rst mismatch",   32'(mm1), 32'h0);
        chk("mid-rst n5 valid",   32'(ov5), 32'h0);
        chk("mid-rst n5 data",    32'(od5), 32'h0);
        chk("mid-rst lim1 fault", 32'(f3),  32'h0);
        chk("mid-rst lim1 any",   32'(af3), 32'h0);
        chk("mid-rst lim1 cnt",   32'(ec3), 32'h0);
        // reset held across an edge keeps everything at zero
        step();
        chk("held-rst out_valid", 32'(ov1), 32'h0);
        chk("held-rst lim1 fault", 32'(f3), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/maj_vote_tmr.md
Name: maj_vote_tmr

Overview:
- Parametrised, registered N-channel bitwise majority voter with per-channel fault supervision.
- Takes N_CH redundant WIDTH-bit words per valid sample and outputs the bitwise majority one cycle later.
- Tracks consecutive disagreements per channel and raises a sticky fault flag when a channel disagrees for ERR_LIMIT consecutive valid samples.
- Generalises the 3-input single-bit combinational voter for redundant datapaths (TMR/5MR).

Parameters:
- N_CH, 3, number of redundant channels; odd and >= 3 (elaboration error otherwise).
- WIDTH, 8, bits per channel word; >= 1.
- ERR_LIMIT, 4, consecutive mismatching valid samples that set a channel fault; 1 .. 2^CNT_W-1.
- CNT_W, 4, width of each per-channel consecutive-mismatch counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  ch_data holds a sample this cycle.
- ch_data  input  N_CH*WIDTH  channel words; channel k occupies bits [k*WIDTH +: WIDTH].
- clr_fault  input  1  synchronous clear of all counters and fault flags.
- out_valid  output  1  out_data holds a voted word.
- out_data  output  WIDTH  registered bitwise majority.
- mismatch  output  N_CH  bit k = channel k differed from the vote on the last valid sample.
- fault  output  N_CH  sticky per-channel fault flags.
- any_fault  output  1  OR of fault.
- err_cnt  output  N_CH*CNT_W  per-channel consecutive-mismatch counters, same packing as ch_data.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs and internal state go to 0 immediately and stay 0 until the first clk edge after release.
- Vote:
  - Bit b of the vote is 1 iff more than N_CH/2 (integer division) channels have bit b = 1.
  - N_CH is odd, so ties cannot occur.
  - Popcount logic uses a width of at least clog2(N_CH+1).
- Latency: on the clk edge where in_valid = 1, out_data <= vote and out_valid <= 1.
- When in_valid = 0: out_valid <= 0; out_data and mismatch hold their previous values.
- mismatch[k]: updated only on valid samples; 1 iff channel k's word != vote in any bit.
- Per-channel state, derived from err_cnt/fault:
  - OK: cnt = 0, fault = 0.
  - SUSPECT: 0 < cnt < ERR_LIMIT.
  - FAULT: fault = 1.
- Counter transitions, on valid samples only:
  - Mismatch: cnt increments, saturating at 2^CNT_W-1.
  - Match: cnt <= 0, unless the channel is in FAULT.
  - When the incremented value equals ERR_LIMIT, fault[k] <= 1 on the same edge.
  - FAULT is sticky: later matches do not clear fault or cnt; cnt continues to count mismatches up to saturation.
- Faulted channels still participate in the vote. Exclusion is out of scope.
- clr_fault = 1 on an edge: all cnt <= 0 and all fault <= 0.
  - Clear wins over a simultaneous increment or fault set.
  - The vote and out_data for a simultaneous valid sample are still produced normally, and mismatch is still updated.
- any_fault is registered and consistent with fault on the same cycle.
- Boundaries:
  - ERR_LIMIT = 1 faults on the first mismatch.
  - A channel may mismatch on every sample without counter wrap.
  - If all channels differ pairwise, every channel whose word != vote is flagged, possibly all N_CH.
  - Reset asserted mid-stream discards the in-flight sample: out_valid = 0.

Test Plan (N_CH=3, WIDTH=8, ERR_LIMIT=4 unless noted):
- Basic vote: ch0=0xA5, ch1=0xA5, ch2=0x5A, in_valid=1 -> next cycle out_data=0xA5, out_valid=1, mismatch=3'b100, err_cnt ch2=1, fault=0.
- Bitwise mix: ch0=0xF0, ch1=0xCC, ch2=0xAA -> out_data=0xE8, mismatch=3'b111; all counters = 1.
- Fault onset: ch1 disagrees on 4 consecutive valid samples, with in_valid=0 gaps between them -> fault=3'b010 and any_fault=1 on the 4th output cycle; counter stays 4 through the gaps. Then 1 matching sample -> fault and counter unchanged.
- Counter reset: ch2 mismatches 3 times, then matches -> err_cnt ch2 = 0, fault=0.
- Clear priority: clr_fault=1 on the same edge as ch0's 4th mismatch -> fault=0, err_cnt=0, out_data still valid with mismatch=3'b001.
- Reset mid-stream: assert rst_n=0 between edges while out_valid=1 -> out_valid, out_data, fault, and err_cnt read 0 immediately. Repeat with N_CH=5, WIDTH=1: inputs 1,1,0,0,1 -> out_data=1.
